unary_acc_border: RTL and testbench
===================================

UNARY_ACC_BORDER -- requirements
Module: unary_acc_border

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; magnitude fields are WIDTH-1 bits.
REQ-002 SHALL have parameter ACCW, default 32, signed partial-sum width; ACCW >= WIDTH+1.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 init  input  1  start a window; same cycle as the init of the upstream border multiplier.
REQ-006 clr  input  1  abort current window, synchronous.
REQ-007 i_len  input  WIDTH-1  window length in cycles; equals the magnitude driven as i_data_i to the upstream multiplier.
REQ-008 i_sign  input  1  product sign (1 = negative), sampled at init.
REQ-009 i_psum  input  ACCW  signed incoming partial sum, sampled at init.
REQ-010 i_bit  input  1  unary product bit stream from the upstream multiplier o_bit.
REQ-011 o_psum  output  ACCW  signed updated partial sum, registered.
REQ-012 o_valid  output  1  o_psum holds a completed result.
REQ-013 o_ready  input  1  downstream accepts o_psum when o_valid & o_ready.
REQ-014 o_idle  output  1  block is in IDLE and can take init.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; o_idle = (state == IDLE).
REQ-016 IDLE, init=1: latch i_len into window counter, i_sign, i_psum; clear ones counter; go RUN (i_len != 0) or DONE with o_psum = i_psum (i_len == 0).
REQ-017 RUN: each cycle window counter != 0, ones counter += i_bit, window counter -= 1; i_bit ignored in IDLE and DONE.
REQ-018 On the edge where window counter goes 1 -> 0, SHALL register o_psum = psum + (sign ? -ones : +ones), including that cycle's i_bit, enter DONE and assert o_valid; latency from init edge to o_valid = i_len + 1 edges.
REQ-019 Ones counter SHALL be WIDTH-1 bits and never exceed i_len; addend sign-extended to ACCW.
REQ-020 Without saturation, the add SHALL wrap modulo 2^ACCW.
REQ-021 DONE: o_valid and o_psum SHALL hold stable until o_valid & o_ready; then go IDLE, o_valid=0.
REQ-022 DONE with o_ready=1 and init=1 in same cycle: SHALL accept result and start the new window (back-to-back), no idle cycle.
REQ-023 DONE with o_ready=0: init SHALL be ignored.
REQ-024 RUN with init=1: SHALL discard current ones count and restart the window with the new inputs.
REQ-025 clr=1 in any state SHALL go IDLE, clear counters, deassert o_valid, discard any result; clr has priority over init and o_ready.
REQ-026 o_psum SHALL retain its last value outside DONE.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, o_valid=0, o_psum=0, all counters and latched sign/psum to 0.
REQ-028 Reset mid-RUN or mid-DONE SHALL lose the window with no output pulse after release.
REQ-029 First init SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ACC_SAT_EN defined: add SHALL saturate to [-2^(ACCW-1), 2^(ACCW-1)-1].
REQ-031 Macro ACC_SAT_EN undefined: add SHALL wrap per REQ-020; no saturation logic present.

Verification
REQ-032 i_len=5, i_sign=0, i_psum=100, i_bit=1,0,1,1,0 -> o_valid at 6th edge after init, o_psum=103.
REQ-033 i_len=0, i_psum=-7 -> o_valid one edge after init, o_psum=-7; o_ready=1 -> IDLE next edge.
REQ-034 i_len=3, i_sign=1, i_psum=2, i_bit all 1 -> o_psum=-1; hold o_ready=0 10 cycles -> o_psum stable, init ignored.
REQ-035 i_len=4 run, clr at 2nd RUN cycle -> IDLE, no o_valid; rst_n pulse mid-RUN -> o_psum=0, o_valid=0.
REQ-036 ACCW=16, i_psum=32767, i_sign=0, 2 ones -> o_psum=32767 with ACC_SAT_EN, -32767 without.
REQ-037 Back-to-back: DONE, o_ready=1 and init=1 same edge, i_len=2, i_psum=10, bits 1,1 -> second o_psum=12 at 3rd edge.

Source files
------------

// File: rtl/unary_acc_border.sv
// unary_acc_border: border accumulator for a unary (bit-stream) multiplier array.
// Counts the ones of an upstream product bit stream over a window of i_len
// cycles, then registers o_psum = i_psum +/- ones and holds it under a
// valid/ready handshake.
// Build option: define ACC_SAT_EN to saturate the final add to the signed
// ACCW range; without it the add wraps modulo 2^ACCW.
//
// state | meaning
// IDLE  | waiting for init, o_idle high
// RUN   | window open, counting ones from i_bit
// DONE  | o_psum/o_valid held until o_valid & o_ready
module unary_acc_border #(
  parameter int WIDTH = 16,
  parameter int ACCW  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init,
  input  logic                   clr,
  input  logic [WIDTH-2:0]       i_len,
  input  logic                   i_sign,
  input  logic signed [ACCW-1:0] i_psum,
  input  logic                   i_bit,
  output logic signed [ACCW-1:0] o_psum,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_idle
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-2:0]       win_q, win_d;
  logic [WIDTH-2:0]       ones_q, ones_d;
  logic                   sign_q, sign_d;
  logic signed [ACCW-1:0] psum_q, psum_d;
  logic signed [ACCW-1:0] o_psum_q, o_psum_d;
  logic                   o_valid_q, o_valid_d;

  logic [WIDTH-2:0]       ones_inc;
  logic [ACCW-1:0]        ones_ext;
  logic signed [ACCW-1:0] addend;
  logic signed [ACCW-1:0] sum;
  logic                   start;

  // The closing edge counts its own i_bit, so the result uses the incremented count.
  assign ones_inc = ones_q + (WIDTH-1)'(i_bit);
  assign ones_ext = ACCW'(ones_inc);
  assign addend   = sign_q ? -ones_ext : ones_ext;

`ifdef ACC_SAT_EN
  logic signed [ACCW:0] sum_wide;
  assign sum_wide = {psum_q[ACCW-1], psum_q} + {addend[ACCW-1], addend};

  // Clamp to the signed ACCW range when the widened sum overflows.
  always_comb begin
    if (sum_wide[ACCW] != sum_wide[ACCW-1]) begin
      sum = sum_wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end else begin
      sum = sum_wide[ACCW-1:0];
    end
  end
`else
  assign sum = psum_q + addend;
`endif

  // Next-state logic; clr overrides everything, a new window may start from IDLE, RUN or an accepted DONE.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    ones_d    = ones_q;
    sign_d    = sign_q;
    psum_d    = psum_q;
    o_psum_d  = o_psum_q;
    o_valid_d = o_valid_q;
    start     = 1'b0;
    if (clr) begin
      state_d   = ST_IDLE;
      win_d     = '0;
      ones_d    = '0;
      o_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: start = init;
        ST_RUN: begin
          if (init) begin
            start = 1'b1;
          end else if (win_q == (WIDTH-1)'(1)) begin
            win_d     = '0;
            ones_d    = ones_inc;
            o_psum_d  = sum;
            o_valid_d = 1'b1;
            state_d   = ST_DONE;
          end else if (win_q != '0) begin
            win_d  = win_q - (WIDTH-1)'(1);
            ones_d = ones_inc;
          end
        end
        ST_DONE: begin
          if (o_ready) begin
            o_valid_d = 1'b0;
            state_d   = ST_IDLE;
            start     = init;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (start) begin
        win_d  = i_len;
        ones_d = '0;
        sign_d = i_sign;
        psum_d = i_psum;
        if (i_len == '0) begin
          state_d   = ST_DONE;
          o_psum_d  = i_psum;
          o_valid_d = 1'b1;
        end else begin
          state_d   = ST_RUN;
          o_valid_d = 1'b0;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      ones_q    <= '0;
      sign_q    <= 1'b0;
      psum_q    <= '0;
      o_psum_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      ones_q    <= ones_d;
      sign_q    <= sign_d;
      psum_q    <= psum_d;
      o_psum_q  <= o_psum_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_psum  = o_psum_q;
  assign o_valid = o_valid_q;
  assign o_idle  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_unary_acc_border.sv
// Testbench for unary_acc_border (WIDTH=8, ACCW=16).
// Inputs change 1ns after the rising edge; the scoreboard monitor samples the
// handshake on the falling edge, ahead of the edge that accepts the result.
module tb_unary_acc_border;

  localparam int WIDTH = 8;
  localparam int ACCW  = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   init;
  logic                   clr;
  logic [WIDTH-2:0]       i_len;
  logic                   i_sign;
  logic signed [ACCW-1:0] i_psum;
  logic                   i_bit;
  logic signed [ACCW-1:0] o_psum;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_idle;

  int     n_chk  = 0;
  int     n_pass = 0;
  longint exp_q[$];

  unary_acc_border #(.WIDTH(WIDTH), .ACCW(ACCW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init),
    .clr     (clr),
    .i_len   (i_len),
    .i_sign  (i_sign),
    .i_psum  (i_psum),
    .i_bit   (i_bit),
    .o_psum  (o_psum),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_idle  (o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: exact integer add, then saturate or wrap into ACCW bits.
  function automatic longint model(input longint p, input bit s, input int ones);
    longint r;
    longint m;
    m = longint'(1) << ACCW;
    r = s ? p - ones : p + ones;
`ifdef ACC_SAT_EN
    if (r > m / 2 - 1) r = m / 2 - 1;
    if (r < -(m / 2)) r = -(m / 2);
`else
    r = ((r % m) + m) % m;
    if (r >= m / 2) r = r - m;
`endif
    return r;
  endfunction

  // Scoreboard: every accepted result is compared against the oldest expectation.
  initial begin
    longint e;
    forever begin
      @(negedge clk);
      if (rst_n && !clr && o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_psum", o_psum, e);
        end
      end
    end
  end

  // Starts a window (init on the next edge), streams bits LSB first, checks o_valid timing.
  task automatic run_window(input int len, input bit s, input longint p,
                            input logic [31:0] bits, input longint exp, input string tag);
    init   = 1'b1;
    i_len  = len[WIDTH-2:0];
    i_sign = s;
    i_psum = p[ACCW-1:0];
    i_bit  = 1'b0;
    exp_q.push_back(exp);
    for (int k = 0; k <= len; k++) begin
      @(posedge clk); #1;
      init    = 1'b0;
      o_ready = 1'b0;
      i_bit   = (k < len) ? bits[k] : 1'b0;
      chk({tag, "_valid"}, o_valid, (k == len));
    end
  endtask

  task automatic drain(input string tag);
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    chk({tag, "_idle"}, o_idle, 1);
    chk({tag, "_valid_low"}, o_valid, 0);
  endtask

  initial begin
    longint sat_a, sat_b;
`ifdef ACC_SAT_EN
    sat_a = 32767;
    sat_b = -32768;
`else
    sat_a = -32767;
    sat_b = 32765;
`endif
    rst_n = 1'b0; init = 1'b0; clr = 1'b0; i_len = '0; i_sign = 1'b0;
    i_psum = '0; i_bit = 1'b0; o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", o_idle, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_psum", o_psum, 0);
    rst_n = 1'b1;

    // First window starts on the first edge after reset release.
    run_window(5, 1'b0, 100, 32'b01101, 103, "w_basic");
    drain("w_basic");

    run_window(0, 1'b0, -7, 32'b0, -7, "w_len0");
    drain("w_len0");

    run_window(3, 1'b1, 2, 32'b111, -1, "w_neg");
    for (int c = 0; c < 10; c++) begin
      init   = c[0];
      i_len  = 7'd5;
      i_psum = 16'sd999;
      @(posedge clk); #1;
      chk("hold_valid", o_valid, 1);
      chk("hold_psum", o_psum, -1);
    end
    init = 1'b0;
    drain("w_neg");

    // clr on the second RUN cycle aborts the window.
    init = 1'b1; i_len = 7'd4; i_sign = 1'b0; i_psum = 16'sd77;
    @(posedge clk); #1;
    init = 1'b0; i_bit = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_idle", o_idle, 1);
    chk("clr_valid", o_valid, 0);
    chk("clr_psum_kept", o_psum, -1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("clr_no_valid", o_valid, 0);
    end

    // Reset in the middle of RUN.
    init = 1'b1; i_len = 7'd4; i_psum = 16'sd50;
    @(posedge clk); #1;
    init = 1'b0; i_bit = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_psum", o_psum, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_idle", o_idle, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", o_valid, 0);
    end

    // init during RUN restarts with the new operands.
    init = 1'b1; i_len = 7'd6; i_sign = 1'b0; i_psum = 16'sd1000;
    @(posedge clk); #1;
    init = 1'b0; i_bit = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    run_window(3, 1'b0, 5, 32'b101, 7, "w_restart");
    drain("w_restart");

    run_window(2, 1'b0, 32767, 32'b11, sat_a, "w_ovf_pos");
    drain("w_ovf_pos");
    run_window(3, 1'b1, -32768, 32'b111, sat_b, "w_ovf_neg");

    // Back-to-back: accept and restart on the same edge.
    o_ready = 1'b1;
    run_window(2, 1'b0, 10, 32'b11, 12, "w_b2b");
    drain("w_b2b");

    for (int r = 0; r < 6; r++) begin
      int          len;
      bit          s;
      longint      p;
      logic [31:0] bits;
      logic [31:0] mask;
      len  = $urandom_range(0, 20);
      s    = 1'($urandom_range(0, 1));
      p    = longint'($urandom_range(0, 65535)) - 32768;
      bits = $urandom;
      mask = (len == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - len));
      run_window(len, s, p, bits, model(p, s, $countones(bits & mask)), "w_rand");
      drain("w_rand");
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
